// File: rtl/boot_ram.sv
// Single-port synchronous RAM with a byte-stream boot loader that holds the core in reset until the image is in.
// Optional core write protection of the low PROT_TOP words: define BOOT_RAM_WPROT_EN.
module boot_ram #(
  parameter int N        = 16,
  parameter int A        = 8,
  parameter int PROT_TOP = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rw,
  input  logic [15:0]  addr,
  input  logic [N-1:0] wdata,
  output logic [N-1:0] rdata,
  output logic         cpu_rst,
  input  logic [7:0]   ld_byte,
  input  logic         ld_valid,
  input  logic         ld_last,
  output logic         ld_ready,
  output logic         boot_done,
  output logic [A:0]   word_count
);

  typedef enum logic [1:0] {
    LD_HI = 2'd0,
    LD_LO = 2'd1,
    RUN   = 2'd2
  } state_e;

  state_e         state_q;
  logic [7:0]     hi_q;
  logic [A:0]     wcnt_q;
  logic [N-1:0]   rdata_q;
  logic           cpu_rst_q;
  logic           boot_done_q;

  logic [N-1:0]   mem [0:(1<<A)-1];

  logic           accept_s;
  logic           ld_we_s;
  logic [N-1:0]   ld_wdata_s;
  logic           cpu_we_s;
  logic           prot_hit_s;
  logic [A-1:0]   ptr_s;
  logic [A-1:0]   caddr_s;
  logic           ptr_full_s;
  logic           unused_s;

  assign ld_ready   = (state_q != RUN) && !rst;
  assign accept_s   = ld_valid && ld_ready;
  assign ptr_s      = wcnt_q[A-1:0];
  assign ptr_full_s = &ptr_s;
  assign caddr_s    = addr[A-1:0];
  assign prot_hit_s = int'(caddr_s) < PROT_TOP;

  assign rdata      = rdata_q;
  assign cpu_rst    = cpu_rst_q;
  assign boot_done  = boot_done_q;
  assign word_count = wcnt_q;

  // Loader word assembly and core write qualification.
  always_comb begin
    ld_we_s    = 1'b0;
    ld_wdata_s = '0;
    if (accept_s) begin
      case (state_q)
        LD_HI: begin
          if (ld_last) begin
            ld_we_s    = 1'b1;
            ld_wdata_s = N'({ld_byte, 8'h00});
          end else begin
            ld_we_s    = 1'b0;
          end
        end
        LD_LO: begin
          ld_we_s    = 1'b1;
          ld_wdata_s = N'({hi_q, ld_byte});
        end
        default: begin
          ld_we_s    = 1'b0;
        end
      endcase
    end else begin
      ld_we_s = 1'b0;
    end
  end

`ifdef BOOT_RAM_WPROT_EN
  assign cpu_we_s = (state_q == RUN) && !rst && !rw && !prot_hit_s;
  assign unused_s = ^addr[15:A];
`else
  assign cpu_we_s = (state_q == RUN) && !rst && !rw;
  assign unused_s = ^{addr[15:A], prot_hit_s};
`endif

  // Memory array; contents deliberately survive rst.
  always_ff @(posedge clk) begin
    if (ld_we_s) begin
      mem[ptr_s] <= ld_wdata_s;
    end else if (cpu_we_s) begin
      mem[caddr_s] <= wdata;
    end
  end

  // Loader FSM, word counter and registered core-facing outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LD_HI;
      hi_q        <= 8'h00;
      wcnt_q      <= '0;
      rdata_q     <= '0;
      cpu_rst_q   <= 1'b1;
      boot_done_q <= 1'b0;
    end else begin
      case (state_q)
        LD_HI: begin
          if (accept_s) begin
            hi_q <= ld_byte;
            if (ld_last) begin
              wcnt_q      <= wcnt_q + (A+1)'(1);
              state_q     <= RUN;
              cpu_rst_q   <= 1'b0;
              boot_done_q <= 1'b1;
            end else begin
              state_q <= LD_LO;
            end
          end
        end
        LD_LO: begin
          if (accept_s) begin
            wcnt_q <= wcnt_q + (A+1)'(1);
            // The last address ends the load even without ld_last.
            if (ld_last || ptr_full_s) begin
              state_q     <= RUN;
              cpu_rst_q   <= 1'b0;
              boot_done_q <= 1'b1;
            end else begin
              state_q <= LD_HI;
            end
          end
        end
        RUN: begin
          if (rw) begin
            rdata_q <= mem[caddr_s];
          end
        end
        default: begin
          state_q <= LD_HI;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_boot_ram.sv
// Randomized scoreboard bench for boot_ram: a transaction-level model predicts memory, rdata and loader status.
module tb_boot_ram;
  localparam int N = 16;
  localparam int A = 8;
  localparam int DEPTH = 1 << A;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         rw = 1'b1;
  logic [15:0]  addr = 16'h0000;
  logic [N-1:0] wdata = 16'h0000;
  logic [N-1:0] rdata;
  logic         cpu_rst;
  logic [7:0]   ld_byte = 8'h00;
  logic         ld_valid = 1'b0;
  logic         ld_last = 1'b0;
  logic         ld_ready;
  logic         boot_done;
  logic [A:0]   word_count;

  boot_ram #(.N(N), .A(A), .PROT_TOP(16)) dut (
    .clk(clk), .rst(rst), .rw(rw), .addr(addr), .wdata(wdata), .rdata(rdata),
    .cpu_rst(cpu_rst), .ld_byte(ld_byte), .ld_valid(ld_valid), .ld_last(ld_last),
    .ld_ready(ld_ready), .boot_done(boot_done), .word_count(word_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [15:0] exp; } exp_t;
  exp_t sb[$];

  // Reference model state.
  logic [15:0] m_mem [DEPTH];
  bit          m_known [DEPTH];
  bit          m_loading = 1'b1;
  int          m_ptr = 0;
  bit          m_have_hi = 1'b0;
  logic [7:0]  m_hi = 8'h00;
  logic [15:0] m_rdata = 16'h0000;
  bit          m_rdata_known = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: compares rdata whenever an expectation matures.
  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      exp_t e;
      e = sb.pop_front();
      chk("rdata", {16'h0, rdata}, {16'h0, e.exp});
    end
  end

  function automatic bit prot(input logic [15:0] a);
`ifdef BOOT_RAM_WPROT_EN
    return a[A-1:0] < 16;
`else
    return a[0] && 1'b0;
`endif
  endfunction

  function automatic void put_word(input logic [15:0] w);
    m_mem[m_ptr] = w;
    m_known[m_ptr] = 1'b1;
    m_ptr++;
    if (m_ptr == DEPTH) m_loading = 1'b0;
  endfunction

  // One clock: model the effect of the currently driven inputs, queue the rdata expectation, advance.
  task automatic tick();
    bit acc;
    acc = ld_valid && m_loading && !rst;
    if (rst) begin
      m_loading = 1'b1; m_ptr = 0; m_have_hi = 1'b0;
      m_rdata = 16'h0000; m_rdata_known = 1'b1;
    end else begin
      if (!m_loading) begin
        if (rw) begin
          m_rdata = m_mem[addr[A-1:0]];
          m_rdata_known = m_known[addr[A-1:0]];
        end else if (!prot(addr)) begin
          m_mem[addr[A-1:0]] = wdata;
          m_known[addr[A-1:0]] = 1'b1;
        end
      end
      if (acc) begin
        if (!m_have_hi) begin
          if (ld_last) begin
            put_word({ld_byte, 8'h00});
            m_loading = 1'b0;
          end else begin
            m_hi = ld_byte;
            m_have_hi = 1'b1;
          end
        end else begin
          put_word({m_hi, ld_byte});
          m_have_hi = 1'b0;
          if (ld_last) m_loading = 1'b0;
        end
      end
    end
    if (m_rdata_known) sb.push_back('{cyc + 1, m_rdata});
    @(posedge clk);
    #1;
  endtask

  task automatic rand_bus();
    rw = 1'($urandom);
    addr = 16'($urandom);
    wdata = 16'($urandom);
  endtask

  task automatic check_status();
    chk("word_count", 32'(word_count), 32'(m_ptr));
    chk("cpu_rst", 32'(cpu_rst), 32'(m_loading));
    chk("boot_done", 32'(boot_done), 32'(!m_loading));
  endtask

  // Offer one byte, optionally after idle gap cycles; bus inputs are random throughout.
  task automatic send_byte(input logic [7:0] b, input bit last, input int max_gap);
    int gap;
    gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    for (int g = 0; g < gap; g++) begin
      ld_valid = 1'b0;
      rand_bus();
      tick();
      chk("cpu_rst_gap", 32'(cpu_rst), 32'(m_loading));
    end
    ld_valid = 1'b1; ld_byte = b; ld_last = last;
    rand_bus();
    chk("ld_ready", 32'(ld_ready), 32'(m_loading));
    tick();
    ld_valid = 1'b0; ld_last = 1'b0;
    check_status();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rand_bus();
    tick();
    chk("rst_ld_ready", 32'(ld_ready), 32'd0);
    chk("rst_word_count", 32'(word_count), 32'd0);
    chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("rst_boot_done", 32'(boot_done), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_ld_ready", 32'(ld_ready), 32'd1);
  endtask

  task automatic bus_op(input bit r, input logic [15:0] a, input logic [15:0] d);
    rw = r; addr = a; wdata = d;
    tick();
  endtask

  // Random reads of loaded words and random writes.
  task automatic run_traffic(input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(2, 0) == 0) bus_op(1'b0, 16'($urandom), 16'($urandom));
      else bus_op(1'b1, 16'($urandom_range(m_ptr - 1, 0)) | (16'($urandom) & 16'hFF00), 16'h0000);
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin m_mem[i] = 16'h0000; m_known[i] = 1'b0; end

    do_reset();
    chk("reset_rdata", 32'(rdata), 32'd0);

    // Directed three-byte image with gaps inside the first word.
    send_byte(8'hA2, 1'b0, 0);
    send_byte(8'h02, 1'b0, 3);
    send_byte(8'hA8, 1'b1, 2);
    chk("boot_word_count", 32'(word_count), 32'd2);
    bus_op(1'b1, 16'h0001, 16'h0000);
    chk("read_w1", 32'(rdata), 32'h0000A800);
    bus_op(1'b1, 16'h0101, 16'h0000);
    bus_op(1'b1, 16'h0000, 16'h0000);
    bus_op(1'b0, 16'h0005, 16'h0F0F);
    bus_op(1'b1, 16'h0005, 16'h0000);
    bus_op(1'b0, 16'h0020, 16'h1234);
    bus_op(1'b1, 16'h0020, 16'h0000);
    bus_op(1'b0, 16'h0021, 16'hBEEF);
    bus_op(1'b0, 16'h0020, 16'h5555);
    run_traffic(20);

    // Reset mid-load after word 3, then reload a random image.
    do_reset();
    for (int i = 0; i < 8; i++) send_byte(8'($urandom), 1'b0, 2);
    rand_bus();
    tick();
    do_reset();
    for (int i = 0; i < 12; i++) send_byte(8'($urandom), i == 11, 2);
    chk("reload_word_count", 32'(word_count), 32'd6);
    run_traffic(40);

    // Odd-length image ending on a high byte.
    do_reset();
    for (int i = 0; i < 7; i++) send_byte(8'($urandom), i == 6, 1);
    run_traffic(20);

    // Fill all of memory without ld_last; surplus bytes must be refused.
    do_reset();
    for (int i = 0; i < 2 * DEPTH; i++) send_byte(8'($urandom), 1'b0, (i % 37 == 0) ? 2 : 0);
    chk("full_word_count", 32'(word_count), 32'(DEPTH));
    for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1'($urandom), 1);
    chk("full_ld_ready", 32'(ld_ready), 32'd0);
    run_traffic(60);

    rw = 1'b1; addr = 16'h0000;
    tick();
    @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
